// File: rtl/frame_copy_scheduler.sv
// frame_copy_scheduler
// Owns the data-memory read port. The CPU normally drives it. Once the CPU
// has finished a frame and vertical sync arrives, the CPU is stalled and the
// rect copy DMA gets the port for a fixed copy window. After that window the
// port goes back to the CPU. Vsyncs that arrive while the CPU is still
// building a frame are counted as dropped frames, and that count saturates.

`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif

module frame_copy_scheduler #(
  parameter int ADDR_WIDTH  = `DATA_ADDR_WIDTH,
  parameter int COPY_CYCLES = 9984,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  cpu_frame_done,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  cpu_stall,
  output logic                  copy_start,
  output logic                  copy_busy,
  output logic                  copy_done,
  output logic [DROP_WIDTH-1:0] dropped_frames
);

  // The counter never reaches COPY_CYCLES, so $clog2 bits are enough.
  // The width is forced to at least 1 so that a one-cycle window still works.
  localparam int CNT_W = (COPY_CYCLES > 1) ? $clog2(COPY_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(COPY_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = DROP_WIDTH'(1);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    START = 2'd2,
    COPY  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [DROP_WIDTH-1:0]   drop_r, drop_s;
  logic                    copy_start_r, copy_busy_r, cpu_stall_r, copy_done_r;

  // Next-state, copy-window counter and dropped-frame accounting
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    drop_s  = drop_r;
    case (state_r)
      IDLE: begin
        if (cpu_frame_done && vsync) begin
          state_s = START;
        end else if (cpu_frame_done) begin
          state_s = ARMED;
        end else if (vsync) begin
          if (drop_r != DROP_MAX) begin
            drop_s = drop_r + DROP_ONE;
          end else begin
            drop_s = drop_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (vsync) begin
          state_s = START;
        end else begin
          state_s = ARMED;
        end
      end
      START: begin
        state_s = COPY;
        cnt_s   = '0;
      end
      COPY: begin
        // The counter holds at its last value on exit, so it cannot wrap
        if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter and registered output decode, with the outputs taken from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      drop_r       <= '0;
      copy_start_r <= 1'b0;
      copy_busy_r  <= 1'b0;
      cpu_stall_r  <= 1'b0;
      copy_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      drop_r       <= drop_s;
      copy_start_r <= (state_s == START);
      copy_busy_r  <= (state_s == START) || (state_s == COPY);
      cpu_stall_r  <= (state_s != IDLE);
      copy_done_r  <= (state_s == COPY) && (cnt_s == CNT_LAST);
    end
  end

  // Port mux: the DMA owns the address while the window is open, and CPU writes are squashed while stalled
  always_comb begin
    mem_addr = copy_busy_r ? dma_addr : cpu_addr;
    mem_we   = cpu_we & ~cpu_stall_r;
  end

  assign copy_start     = copy_start_r;
  assign copy_busy      = copy_busy_r;
  assign cpu_stall      = cpu_stall_r;
  assign copy_done      = copy_done_r;
  assign dropped_frames = drop_r;

endmodule

// File: tb/tb_frame_copy_scheduler.sv
// Testbench for frame_copy_scheduler: directed frame scenarios with literal
// expectations, followed by randomized traffic. A per-cycle compare process
// checks every output against a window-position reference model.

module tb_frame_copy_scheduler;

  localparam int C  = 150;
  localparam int DW = 2;
  localparam int AW = 12;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset, vsync, cpu_frame_done, cpu_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic          mem_we, cpu_stall, copy_start, copy_busy, copy_done;
  logic [DW-1:0] dropped_frames;

  int checks = 0;
  int errors = 0;

  frame_copy_scheduler #(.ADDR_WIDTH(AW), .COPY_CYCLES(C), .DROP_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .cpu_frame_done(cpu_frame_done),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .dma_addr(dma_addr),
    .mem_addr(mem_addr), .mem_we(mem_we), .cpu_stall(cpu_stall),
    .copy_start(copy_start), .copy_busy(copy_busy), .copy_done(copy_done),
    .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_pos = -1 outside the window, 0 on the start cycle,
  // and 1..C on the copy cycles. m_armed means the frame is done and vsync is awaited.
  int m_pos   = -1;
  bit m_armed = 1'b0;
  int m_drops = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pos <= -1; m_armed <= 1'b0; m_drops <= 0; m_valid <= 1'b1;
    end else if (m_pos >= 0) begin
      m_pos <= (m_pos == C) ? -1 : m_pos + 1;
    end else if (m_armed) begin
      if (vsync) begin m_armed <= 1'b0; m_pos <= 0; end
    end else if (cpu_frame_done && vsync) begin
      m_pos <= 0;
    end else if (cpu_frame_done) begin
      m_armed <= 1'b1;
    end else if (vsync) begin
      m_drops <= (m_drops >= DROP_MAX) ? DROP_MAX : m_drops + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_copy_start", 32'(copy_start), 32'(m_pos == 0));
      chk("m_copy_busy",  32'(copy_busy),  32'(m_pos >= 0));
      chk("m_cpu_stall",  32'(cpu_stall),  32'(m_armed || m_pos >= 0));
      chk("m_copy_done",  32'(copy_done),  32'(m_pos == C));
      chk("m_mem_addr",   32'(mem_addr),   32'((m_pos >= 0) ? dma_addr : cpu_addr));
      chk("m_mem_we",     32'(mem_we),     32'(cpu_we && !(m_armed || m_pos >= 0)));
      chk("m_dropped",    32'(dropped_frames), 32'(m_drops));
    end
  end

  task automatic cyc(input logic r, input logic f, input logic v, input logic w);
    @(posedge clk);
    #1;
    reset          = r;
    cpu_frame_done = f;
    vsync          = v;
    cpu_we         = w;
    cpu_addr       = AW'($urandom);
    dma_addr       = AW'($urandom);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; cpu_frame_done = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; dma_addr = '0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_copy_start", 32'(copy_start), 32'd0);
    chk("rst_copy_busy",  32'(copy_busy),  32'd0);
    chk("rst_copy_done",  32'(copy_done),  32'd0);
    chk("rst_cpu_stall",  32'(cpu_stall),  32'd0);
    chk("rst_dropped",    32'(dropped_frames), 32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'(cpu_addr));

    // Normal frame: done at t=10, vsync at t=20, cpu_we held high throughout
    for (int t = 0; t <= C + 25; t++) begin
      cyc(1'b0, t == 10, t == 20, 1'b1);
      @(negedge clk);
      if (t == 10) chk("nf_stall_before", 32'(cpu_stall), 32'd0);
      if (t == 11) chk("nf_stall_armed",  32'(cpu_stall), 32'd1);
      if (t >= 11 && t <= 21 + C) chk("nf_we_blocked", 32'(mem_we), 32'd0);
      if (t == 20 || t == 22) chk("nf_start_off", 32'(copy_start), 32'd0);
      if (t == 21) chk("nf_start_on", 32'(copy_start), 32'd1);
      if (t >= 21 && t <= 21 + C) chk("nf_dma_addr", 32'(mem_addr), 32'(dma_addr));
      if (t == 20 + C) chk("nf_done_early", 32'(copy_done), 32'd0);
      if (t == 21 + C) chk("nf_done", 32'(copy_done), 32'd1);
      if (t == 22 + C) begin
        chk("nf_stall_release", 32'(cpu_stall), 32'd0);
        chk("nf_we_restored",   32'(mem_we),    32'd1);
        chk("nf_cpu_addr",      32'(mem_addr),  32'(cpu_addr));
      end
    end

    // Missed frames: two vsyncs while idle
    for (int t = 0; t < 10; t++) begin
      cyc(1'b0, 1'b0, (t == 2) || (t == 5), 1'b0);
      @(negedge clk);
      chk("mf_no_start", 32'(copy_start), 32'd0);
      chk("mf_no_stall", 32'(cpu_stall),  32'd0);
      if (t == 9) chk("mf_dropped_2", 32'(dropped_frames), 32'd2);
    end

    // Saturation: five idle vsyncs on a 2-bit counter
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 12; t++) begin
      cyc(1'b0, 1'b0, (t % 2 == 0) && (t < 10), 1'b0);
      @(negedge clk);
      if (t == 3)  chk("sat_dropped_2", 32'(dropped_frames), 32'd2);
      if (t == 11) chk("sat_dropped_3", 32'(dropped_frames), 32'd3);
    end

    // Simultaneous done+vsync, then reset while the copy counter reads 100
    for (int k = 0; k <= 104; k++) begin
      cyc(k == 102, k == 0, k == 0, 1'b1);
      @(negedge clk);
      if (k == 0) chk("sim_idle_stall", 32'(cpu_stall), 32'd0);
      if (k == 1) begin
        chk("sim_start", 32'(copy_start), 32'd1);
        chk("sim_dropped_same", 32'(dropped_frames), 32'd3);
      end
      if (k == 2)   chk("sim_start_off", 32'(copy_start), 32'd0);
      if (k == 102) chk("mid_busy", 32'(copy_busy), 32'd1);
      if (k == 103) begin
        chk("mid_rst_busy",    32'(copy_busy), 32'd0);
        chk("mid_rst_stall",   32'(cpu_stall), 32'd0);
        chk("mid_rst_addr",    32'(mem_addr),  32'(cpu_addr));
        chk("mid_rst_dropped", 32'(dropped_frames), 32'd0);
        chk("mid_rst_we",      32'(mem_we),    32'd1);
      end
    end

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 20000; i++) begin
      cyc(($urandom % 3000) == 0, ($urandom % 20) == 0, ($urandom % 40) == 0, 1'($urandom));
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
